// File: rtl/ahb_burst_planner.sv
// Splits a beat-counted AHB request into INCR16/INCR8/INCR4 descriptors that never cross BOUNDARY.
// Tail beats are SINGLE by default; define FREEAHB_UNDEF_INCR_EN to emit the tail as one undefined-length INCR.
module ahb_burst_planner #(
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 16,
    parameter int MAX_BEATS = 16,
    parameter int BOUNDARY  = 1024
) (
    input  logic              i_hclk,
    input  logic              i_hreset_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [LEN_W-1:0]  i_req_len,
    input  logic [2:0]        i_req_size,
    input  logic              i_abort,
    output logic              o_desc_valid,
    input  logic              i_desc_ready,
    output logic [ADDR_W-1:0] o_desc_addr,
    output logic [2:0]        o_desc_hburst,
    output logic [LEN_W-1:0]  o_desc_beats,
    output logic              o_desc_last,
    output logic              o_req_err,
    output logic              o_done
);

    localparam int AW1 = ADDR_W + 1;
    localparam logic [AW1-1:0] BOUND      = AW1'(BOUNDARY);
    localparam logic [AW1-1:0] BOUND_MASK = AW1'(BOUNDARY - 1);

    localparam logic [2:0] HB_SINGLE = 3'd0;
    localparam logic [2:0] HB_INCR4  = 3'd3;
    localparam logic [2:0] HB_INCR8  = 3'd5;
    localparam logic [2:0] HB_INCR16 = 3'd7;
`ifdef FREEAHB_UNDEF_INCR_EN
    localparam logic [2:0] HB_INCR   = 3'd1;
    localparam int CW = (AW1 > LEN_W) ? AW1 : LEN_W;
`endif

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        EMIT
    } state_t;

    state_t state;
    state_t next_state;

    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  rem;
    logic [2:0]        size;
    logic [2:0]        desc_hburst;
    logic [LEN_W-1:0]  desc_beats;
    logic              desc_last;
    logic              req_err;
    logic              done;

    logic              req_fire;
    logic              misaligned;
    logic              len_zero;
    logic              accept;
    logic              desc_fire;
    logic [LEN_W-1:0]  rem_after;
    logic [ADDR_W-1:0] size_mask;
    logic [AW1-1:0]    offset;
    logic [AW1-1:0]    span4;
    logic [AW1-1:0]    span8;
    logic [AW1-1:0]    span16;
    logic              fit4;
    logic              fit8;
    logic              fit16;
    logic [2:0]        calc_hburst;
    logic [LEN_W-1:0]  calc_beats;
`ifdef FREEAHB_UNDEF_INCR_EN
    logic [AW1-1:0]    room;
`endif

    assign size_mask  = (ADDR_W'(1) << i_req_size) - ADDR_W'(1);
    assign misaligned = |(i_req_addr & size_mask);
    assign len_zero   = (i_req_len == '0);
    assign req_fire   = i_req_valid && (state == IDLE);
    assign accept     = req_fire && !misaligned && !len_zero;
    assign desc_fire  = (state == EMIT) && i_desc_ready && !i_abort;
    assign rem_after  = rem - desc_beats;

    // Byte offsets and burst spans are compared one bit wider than the address so the sum never wraps.
    assign offset = {1'b0, addr} & BOUND_MASK;
    assign span4  = AW1'(4) << size;
    assign span8  = AW1'(8) << size;
    assign span16 = AW1'(16) << size;
    assign fit4   = (MAX_BEATS >= 4)  && (rem >= LEN_W'(4))  && ((offset + span4)  <= BOUND);
    assign fit8   = (MAX_BEATS >= 8)  && (rem >= LEN_W'(8))  && ((offset + span8)  <= BOUND);
    assign fit16  = (MAX_BEATS >= 16) && (rem >= LEN_W'(16)) && ((offset + span16) <= BOUND);

    always_comb begin
        calc_hburst = HB_SINGLE;
        calc_beats  = LEN_W'(1);
`ifdef FREEAHB_UNDEF_INCR_EN
        room        = (BOUND - offset) >> size;
        calc_hburst = HB_INCR;
        calc_beats  = (CW'(rem) < CW'(room)) ? rem : LEN_W'(room);
`endif
        if (fit16) begin
            calc_hburst = HB_INCR16;
            calc_beats  = LEN_W'(16);
        end else if (fit8) begin
            calc_hburst = HB_INCR8;
            calc_beats  = LEN_W'(8);
        end else if (fit4) begin
            calc_hburst = HB_INCR4;
            calc_beats  = LEN_W'(4);
        end
    end

    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Abort wins over a descriptor handshake in the same cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = CALC;
                end
            end
            CALC: begin
                next_state = i_abort ? IDLE : EMIT;
            end
            EMIT: begin
                if (i_abort) begin
                    next_state = IDLE;
                end else if (i_desc_ready) begin
                    next_state = (rem_after == '0) ? IDLE : CALC;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            addr        <= '0;
            rem         <= '0;
            size        <= '0;
            desc_hburst <= '0;
            desc_beats  <= '0;
            desc_last   <= 1'b0;
            req_err     <= 1'b0;
            done        <= 1'b0;
        end else begin
            req_err <= req_fire && misaligned;
            done    <= (req_fire && !misaligned && len_zero) ||
                       (desc_fire && (rem_after == '0));
            if (accept) begin
                addr <= i_req_addr;
                rem  <= i_req_len;
                size <= i_req_size;
            end
            if ((state == CALC) && !i_abort) begin
                desc_hburst <= calc_hburst;
                desc_beats  <= calc_beats;
                desc_last   <= (calc_beats == rem);
            end
            if (desc_fire) begin
                addr <= addr + (ADDR_W'(desc_beats) << size);
                rem  <= rem_after;
            end
        end
    end

    assign o_req_ready   = (state == IDLE);
    assign o_desc_valid  = (state == EMIT);
    assign o_desc_addr   = addr;
    assign o_desc_hburst = desc_hburst;
    assign o_desc_beats  = desc_beats;
    assign o_desc_last   = desc_last;
    assign o_req_err     = req_err;
    assign o_done        = done;

endmodule

// File: tb/tb_ahb_burst_planner.sv
// Scoreboard bench for ahb_burst_planner: a behavioural planner predicts every descriptor, error and done event.
// Honours FREEAHB_UNDEF_INCR_EN the same way as the design.
module tb_ahb_burst_planner;

    localparam int ADDR_W    = 32;
    localparam int LEN_W     = 16;
    localparam int MAX_BEATS = 16;
    localparam int BOUNDARY  = 1024;

    localparam logic [1:0] K_DESC = 2'd0;
    localparam logic [1:0] K_ERR  = 2'd1;
    localparam logic [1:0] K_DONE = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [2:0]  hb;
        logic [15:0] beats;
        logic        last;
    } exp_t;

    logic              i_hclk;
    logic              i_hreset_n;
    logic              i_req_valid;
    logic              o_req_ready;
    logic [ADDR_W-1:0] i_req_addr;
    logic [LEN_W-1:0]  i_req_len;
    logic [2:0]        i_req_size;
    logic              i_abort;
    logic              o_desc_valid;
    logic              i_desc_ready;
    logic [ADDR_W-1:0] o_desc_addr;
    logic [2:0]        o_desc_hburst;
    logic [LEN_W-1:0]  o_desc_beats;
    logic              o_desc_last;
    logic              o_req_err;
    logic              o_done;

    exp_t sb[$];
    int   n_vec;
    int   n_miss;
    bit   ready_mode;
    bit   ready_force;

    ahb_burst_planner #(
        .ADDR_W    (ADDR_W),
        .LEN_W     (LEN_W),
        .MAX_BEATS (MAX_BEATS),
        .BOUNDARY  (BOUNDARY)
    ) dut (
        .i_hclk        (i_hclk),
        .i_hreset_n    (i_hreset_n),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_addr    (i_req_addr),
        .i_req_len     (i_req_len),
        .i_req_size    (i_req_size),
        .i_abort       (i_abort),
        .o_desc_valid  (o_desc_valid),
        .i_desc_ready  (i_desc_ready),
        .o_desc_addr   (o_desc_addr),
        .o_desc_hburst (o_desc_hburst),
        .o_desc_beats  (o_desc_beats),
        .o_desc_last   (o_desc_last),
        .o_req_err     (o_req_err),
        .o_done        (o_done)
    );

    initial begin
        i_hclk = 1'b0;
        forever #5 i_hclk = ~i_hclk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        n_vec++;
        if (actual !== required) begin
            n_miss++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    function automatic void pushExp(input logic [1:0] kind, input longint unsigned a,
                                    input int hb, input int beats, input bit last);
        exp_t e;
        e.kind  = kind;
        e.addr  = a[31:0];
        e.hb    = 3'(hb);
        e.beats = 16'(beats);
        e.last  = last;
        sb.push_back(e);
    endfunction

    // Reference planner: walks the request in plain byte arithmetic and picks the largest legal burst.
    function automatic void planRequest(input logic [31:0] a, input int len, input int s);
        longint unsigned cur;
        longint unsigned bytes;
        longint unsigned off;
        int r;
        int n;
        int hb;
        bytes = 64'd1 << s;
        cur   = 64'(a);
        if ((cur % bytes) != 0) begin
            pushExp(K_ERR, 0, 0, 0, 1'b0);
            return;
        end
        r = len;
        while (r > 0) begin
            off = cur % BOUNDARY;
            n   = 0;
            hb  = 0;
            if (16 <= MAX_BEATS && r >= 16 && off + 16 * bytes <= BOUNDARY) begin
                n = 16; hb = 7;
            end else if (8 <= MAX_BEATS && r >= 8 && off + 8 * bytes <= BOUNDARY) begin
                n = 8; hb = 5;
            end else if (r >= 4 && off + 4 * bytes <= BOUNDARY) begin
                n = 4; hb = 3;
            end else begin
`ifdef FREEAHB_UNDEF_INCR_EN
                n  = int'((BOUNDARY - off) / bytes);
                if (r < n) n = r;
                hb = 1;
`else
                n  = 1;
                hb = 0;
`endif
            end
            pushExp(K_DESC, cur, hb, n, (n == r));
            cur = (cur + longint'(n) * bytes) % (64'd1 << 32);
            r   = r - n;
        end
        pushExp(K_DONE, 0, 0, 0, 1'b0);
    endfunction

    task automatic popCheck(input logic [1:0] kind, input exp_t seen);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL unexpected_event kind=%0d actual=%0h required=none", kind, seen);
        end else begin
            e = sb.pop_front();
            checkOutput("event", 64'(seen), 64'(e));
        end
    endtask

    // Monitor: every DUT event consumes the oldest prediction.
    initial begin
        exp_t seen;
        forever begin
            @(negedge i_hclk);
            if (i_hreset_n) begin
                if (o_desc_valid && i_desc_ready && !i_abort) begin
                    seen = {K_DESC, o_desc_addr, o_desc_hburst, o_desc_beats, o_desc_last};
                    popCheck(K_DESC, seen);
                end
                if (o_req_err) begin
                    seen = {K_ERR, 52'd0};
                    popCheck(K_ERR, seen);
                end
                if (o_done) begin
                    seen = {K_DONE, 52'd0};
                    popCheck(K_DONE, seen);
                end
            end
        end
    end

    initial begin
        i_desc_ready = 1'b0;
        forever begin
            @(posedge i_hclk);
            #2;
            i_desc_ready = ready_mode ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog expired pending=%0d required=0", sb.size());
        n_miss++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $fatal(1, "[TB] watchdog");
    end

    // Issues one request, returning at the cycle where the first descriptor must be presented.
    task automatic applyStimulus(input logic [31:0] a, input int len, input int s);
        int cnt;
        bit accepted;
        planRequest(a, len, s);
        accepted    = ((a & ((32'd1 << s) - 32'd1)) == 32'd0) && (len != 0);
        i_req_addr  = a;
        i_req_len   = 16'(len);
        i_req_size  = 3'(s);
        i_req_valid = 1'b1;
        cnt = 0;
        while (!o_req_ready && cnt < 200) begin
            @(posedge i_hclk); #1;
            cnt++;
        end
        if (!o_req_ready) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL ready_timeout actual=0 required=1");
        end
        @(posedge i_hclk); #1;
        i_req_valid = 1'b0;
        checkOutput("calc_cycle", 64'({o_req_ready, o_desc_valid}), accepted ? 64'd0 : 64'd2);
        @(posedge i_hclk); #1;
        checkOutput("first_latency", 64'(o_desc_valid), accepted ? 64'd1 : 64'd0);
    endtask

    task automatic drainScoreboard();
        int cnt;
        cnt = 0;
        while (sb.size() != 0 && cnt < 3000) begin
            @(posedge i_hclk); #1;
            cnt++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL drain_timeout actual=%0d pending required=0", sb.size());
            sb.delete();
            i_hreset_n = 1'b0;
            @(posedge i_hclk); #1;
            i_hreset_n = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] a;
        int s;
        int len;
        int sel;
        exp_t e;
        n_vec       = 0;
        n_miss      = 0;
        ready_mode  = 1'b0;
        ready_force = 1'b1;
        i_hreset_n  = 1'b0;
        i_req_valid = 1'b0;
        i_req_addr  = '0;
        i_req_len   = '0;
        i_req_size  = '0;
        i_abort     = 1'b0;
        repeat (3) @(posedge i_hclk);
        #1;
        checkOutput("rst_req_ready", 64'(o_req_ready), 64'd1);
        checkOutput("rst_desc_valid", 64'(o_desc_valid), 64'd0);
        checkOutput("rst_desc_fields", 64'({o_desc_addr, o_desc_hburst, o_desc_beats, o_desc_last}), 64'd0);
        checkOutput("rst_pulses", 64'({o_req_err, o_done}), 64'd0);
        i_hreset_n = 1'b1;
        @(posedge i_hclk); #1;

        $display("[TB] directed: 20 beats from 0x000, W32");
        applyStimulus(32'h000, 20, 2);
        drainScoreboard();
        $display("[TB] directed: 8 beats from 0x3F0 across the 1 KiB boundary");
        applyStimulus(32'h3F0, 8, 2);
        drainScoreboard();
        $display("[TB] directed: 3 beat tail");
        applyStimulus(32'h000, 3, 2);
        drainScoreboard();
        $display("[TB] directed: zero length");
        applyStimulus(32'h100, 0, 2);
        drainScoreboard();

        $display("[TB] directed: misaligned request");
        applyStimulus(32'h002, 4, 2);
        repeat (3) begin
            @(posedge i_hclk); #1;
            checkOutput("err_idle", 64'({o_req_ready, o_desc_valid}), 64'd2);
        end
        drainScoreboard();

        $display("[TB] directed: 5-cycle stall");
        ready_force = 1'b0;
        applyStimulus(32'h000, 20, 2);
        for (int k = 0; k < 5; k++) begin
            e = sb[0];
            checkOutput("stall_hold", 64'({o_desc_valid, o_desc_addr, o_desc_hburst, o_desc_beats, o_desc_last}),
                        64'({1'b1, e.addr, e.hb, e.beats, e.last}));
            @(posedge i_hclk); #1;
        end
        ready_force = 1'b1;
        drainScoreboard();

        $display("[TB] directed: abort on second descriptor");
        ready_force = 1'b0;
        applyStimulus(32'h000, 20, 2);
        ready_force = 1'b1;
        @(posedge i_hclk); #1;
        ready_force = 1'b0;
        @(posedge i_hclk); #1;
        checkOutput("second_desc_valid", 64'(o_desc_valid), 64'd1);
        i_abort     = 1'b1;
        ready_force = 1'b1;
        @(posedge i_hclk); #1;
        i_abort = 1'b0;
        sb.delete();
        checkOutput("abort_idle", 64'({o_req_ready, o_desc_valid}), 64'd2);
        repeat (5) @(posedge i_hclk);
        #1;

        $display("[TB] directed: reset during EMIT");
        ready_force = 1'b0;
        applyStimulus(32'h200, 20, 2);
        i_hreset_n = 1'b0;
        #1;
        sb.delete();
        checkOutput("midrst_ready", 64'(o_req_ready), 64'd1);
        checkOutput("midrst_outputs", 64'({o_desc_valid, o_desc_addr, o_desc_hburst, o_desc_beats, o_desc_last,
                                           o_req_err, o_done}), 64'd0);
        ready_force = 1'b1;
        @(posedge i_hclk); #1;
        i_hreset_n = 1'b1;
        repeat (5) @(posedge i_hclk);
        #1;
        checkOutput("post_rst_idle", 64'({o_req_ready, o_desc_valid}), 64'd2);

        $display("[TB] random requests with random backpressure");
        ready_mode = 1'b1;
        for (int i = 0; i < 60; i++) begin
            s = $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) s = $urandom_range(4, 7);
            a   = $urandom & ~((32'd1 << s) - 32'd1);
            len = $urandom_range(1, 40);
            sel = $urandom_range(0, 9);
            if (sel == 0) a = 32'hFFFF_FF00 & ~((32'd1 << s) - 32'd1);
            if (sel == 1 && s > 0) a = a | 32'd1;
            if (sel == 2) len = 0;
            applyStimulus(a, len, s);
            drainScoreboard();
        end
        ready_mode = 1'b0;

        repeat (4) @(posedge i_hclk);
        #1;
        checkOutput("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ahb_burst_planner.md
AHB_BURST_PLANNER -- requirements
Module: ahb_burst_planner

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDR_W, 32, address width.
- LEN_W, 16, request length width in beats.
- MAX_BEATS, 16, largest fixed burst emitted; legal values 4, 8, 16.
- BOUNDARY, 1024, address boundary in bytes that no burst crosses; power of two.

REQ-002 Ports (name, direction, width, meaning), one per line; clock and reset first:
- i_hclk, in, 1, sole clock.
- i_hreset_n, in, 1, asynchronous active-low reset.
- i_req_valid, in, 1, request valid.
- o_req_ready, out, 1, request accepted.
- i_req_addr, in, ADDR_W, start byte address.
- i_req_len, in, LEN_W, total beats.
- i_req_size, in, 3, HSIZE encoding W8..W1024.
- i_abort, in, 1, synchronous abort.
- o_desc_valid, out, 1, descriptor valid.
- i_desc_ready, in, 1, descriptor accepted.
- o_desc_addr, out, ADDR_W, burst start address.
- o_desc_hburst, out, 3, HBURST encoding.
- o_desc_beats, out, LEN_W, beats in this burst.
- o_desc_last, out, 1, final descriptor of the request.
- o_req_err, out, 1, one-cycle pulse on a rejected request.
- o_done, out, 1, one-cycle pulse on request completion.

Function
REQ-003 The FSM SHALL have states IDLE, CALC and EMIT; o_req_ready=1 only in IDLE.
REQ-004 A handshake (i_req_valid & o_req_ready) SHALL register addr, len (as rem) and size, then move to CALC.
REQ-005 A request with i_req_addr not aligned to 1<<i_req_size SHALL stay in IDLE, pulse o_req_err the next cycle and emit no descriptor.
REQ-006 A request with i_req_len=0 SHALL stay in IDLE, pulse o_done the next cycle and emit no descriptor.
REQ-007 CALC SHALL last exactly one cycle and select the largest N in {16,8,4} such that N<=MAX_BEATS, N<=rem and (addr mod BOUNDARY)+N*(1<<size)<=BOUNDARY; the result is INCR16/INCR8/INCR4 with beats=N.
REQ-008 If no N qualifies, CALC SHALL select the tail form defined under Configuration.
REQ-009 Boundary arithmetic SHALL be carried out at ADDR_W+1 bits so it never wraps.
REQ-010 EMIT SHALL hold o_desc_valid=1 and keep every descriptor field stable until i_desc_ready=1.
REQ-011 On each EMIT handshake: addr += beats<<size; rem -= beats.
- rem>0: next state CALC.
- rem=0: next state IDLE and o_done pulses the following cycle.
REQ-012 o_desc_last SHALL equal 1 exactly when beats==rem.
REQ-013 Latency: a request accepted at cycle T SHALL present its first descriptor at T+2; each following descriptor SHALL appear two cycles after the preceding handshake.
REQ-014 i_abort=1 in CALC or EMIT SHALL return the FSM to IDLE the next cycle and deassert o_desc_valid without pulsing o_done; i_abort SHALL take priority over a simultaneous descriptor handshake.
REQ-015 Address increment SHALL wrap modulo 2^ADDR_W.

Reset
REQ-016 While i_hreset_n=0 the FSM SHALL be in IDLE with o_req_ready=1 and every other output, and all internal registers, at 0.
REQ-017 A reset asserted mid-request SHALL discard the request with no descriptor or pulse afterwards.

Configuration
REQ-018 Macro FREEAHB_UNDEF_INCR_EN SHALL select the tail form.
- Defined: the tail SHALL be emitted as hburst=INCR with beats=min(rem, beats to the next BOUNDARY).
- Undefined: each tail beat SHALL be emitted as hburst=SINGLE with beats=1.

Verification
REQ-019 addr=0x000, len=20, size=W32 -> INCR16@0x000 (16 beats), then INCR4@0x040 (4 beats, last=1), then o_done.
REQ-020 addr=0x3F0, len=8, size=W32 -> INCR4@0x3F0, then INCR4@0x400 (last=1); no descriptor crosses 0x400.
REQ-021 addr=0x000, len=3, size=W32:
- macro defined -> one INCR@0x000, beats=3, last=1.
- macro undefined -> SINGLE descriptors @0x000, 0x004 and 0x008; last=1 on the third only.
REQ-022 i_desc_ready held at 0 for 5 cycles during EMIT -> o_desc_valid and all descriptor fields unchanged for all 5 cycles.
REQ-023 addr=0x002, size=W32 -> o_req_err pulses for one cycle, no o_desc_valid, o_req_ready stays 1.
REQ-024 Stimulus and required response:
- i_abort pulsed during the second descriptor of a len=20 request -> IDLE next cycle, no o_done.
- i_hreset_n pulsed low mid-EMIT -> all outputs 0 except o_req_ready=1.
